// File: rtl/qmax_update.sv
// qmax_update: read-compare-write controller for the per-state max-Q table.
//
// Each transaction takes one (state, candidate) pair and reads the stored
// qmax for that state from the table's registered read port. If the
// candidate is strictly greater, it writes the candidate back.
// Sequence: IDLE -> READ -> CMP -> WRITE -> IDLE (one transaction every 4 cycles).
//
// Optional build macro: QMAX_SIGNED_EN
//   defined   -> candidate and stored value are compared as two's-complement
//   undefined -> the comparison is unsigned (default)
//
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_valid / o_ready       request handshake (o_ready is high only in IDLE)
//   i_state, i_q            state index and candidate Q value
//   o_addr_r / i_qmax       table read address and read data (1-cycle latency)
//   o_addr_w, o_data,
//   o_write_en              table write port
//   o_done, o_updated,
//   o_qmax                  end-of-transaction pulse, write flag, max result
//   o_wr_cnt                saturating count of issued writes
module qmax_update #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [ADDR_WIDTH-1:0] i_state,
    input  logic [DATA_WIDTH-1:0] i_q,
    output logic [ADDR_WIDTH-1:0] o_addr_r,
    input  logic [DATA_WIDTH-1:0] i_qmax,
    output logic [ADDR_WIDTH-1:0] o_addr_w,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_write_en,
    output logic                  o_done,
    output logic                  o_updated,
    output logic [DATA_WIDTH-1:0] o_qmax,
    output logic [CNT_WIDTH-1:0]  o_wr_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_CMP   = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t                r_fsm;
    state_t                w_fsm_nxt;
    logic                  r_ready;
    logic [ADDR_WIDTH-1:0] r_addr_r;   // doubles as the captured state index
    logic [DATA_WIDTH-1:0] r_cand;
    logic [ADDR_WIDTH-1:0] r_addr_w;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_qmax;
    logic                  r_write_en;
    logic                  r_done;
    logic                  r_updated;
    logic [CNT_WIDTH-1:0]  r_wr_cnt;

    logic                  w_accept;
    logic                  w_gt;

    // o_ready is registered: it must read 0 while reset is held even though
    // the FSM already sits in IDLE, and rise at the first edge out of reset.
    assign w_accept = (r_fsm == S_IDLE) && i_valid && r_ready;

`ifdef QMAX_SIGNED_EN
    assign w_gt = $signed(r_cand) > $signed(i_qmax);
`else
    assign w_gt = r_cand > i_qmax;
`endif

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE:  if (w_accept) w_fsm_nxt = S_READ;
            S_READ:  w_fsm_nxt = S_CMP;
            S_CMP:   w_fsm_nxt = S_WRITE;
            S_WRITE: w_fsm_nxt = S_IDLE;
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_fsm      <= S_IDLE;
            r_ready    <= 1'b0;
            r_addr_r   <= '0;
            r_cand     <= '0;
            r_addr_w   <= '0;
            r_data     <= '0;
            r_qmax     <= '0;
            r_write_en <= 1'b0;
            r_done     <= 1'b0;
            r_updated  <= 1'b0;
            r_wr_cnt   <= '0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_ready <= (w_fsm_nxt == S_IDLE);

            if (w_accept) begin
                r_addr_r <= i_state;
                r_cand   <= i_q;
            end

            // i_qmax is the table's registered response to the address
            // presented during READ.
            if (r_fsm == S_CMP) begin
                r_write_en <= w_gt;
                r_addr_w   <= r_addr_r;
                r_data     <= r_cand;
                r_qmax     <= w_gt ? r_cand : i_qmax;
                r_updated  <= w_gt;
                r_done     <= 1'b1;
            end

            if (r_fsm == S_WRITE) begin
                r_write_en <= 1'b0;
                r_done     <= 1'b0;
                r_updated  <= 1'b0;
                // r_updated still carries this transaction's compare result.
                if (r_updated && (r_wr_cnt != {CNT_WIDTH{1'b1}}))
                    r_wr_cnt <= r_wr_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign o_ready    = r_ready;
    assign o_addr_r   = r_addr_r;
    assign o_addr_w   = r_addr_w;
    assign o_data     = r_data;
    assign o_write_en = r_write_en;
    assign o_done     = r_done;
    assign o_updated  = r_updated;
    assign o_qmax     = r_qmax;
    assign o_wr_cnt   = r_wr_cnt;

endmodule

// File: doc/qmax_update.md
# qmax_update

Read-compare-write controller that keeps the per-state maximum-Q table current. It accepts one (state, candidate Q) update per transaction and reads the stored qmax for that state from the table's registered read port. When the candidate is strictly greater, it writes the candidate back through the table's write port. It sits directly upstream of the qmax table, between the Q-update datapath and the BRAM.

## Interface

Parameters:
- ADDR_WIDTH, 8, state index width; must match the table's ADDR_WIDTH.
- DATA_WIDTH, 8, Q value width; must match the table's DATA_WIDTH.
- CNT_WIDTH, 16, width of the write counter.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge. This is the only clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_valid  in  1  update request valid.
- o_ready  out  1  block can accept a request (IDLE).
- i_state  in  ADDR_WIDTH  state index to update.
- i_q  in  DATA_WIDTH  candidate Q value.
- o_addr_r  out  ADDR_WIDTH  table read address.
- i_qmax  in  DATA_WIDTH  table read data, one cycle after o_addr_r.
- o_addr_w  out  ADDR_WIDTH  table write address.
- o_data  out  DATA_WIDTH  table write data.
- o_write_en  out  1  table write strobe, one cycle wide.
- o_done  out  1  one-cycle pulse marking the end of a transaction.
- o_updated  out  1  qualifies o_done; 1 when the table was written.
- o_qmax  out  DATA_WIDTH  resulting max(stored, candidate); valid with o_done.
- o_wr_cnt  out  CNT_WIDTH  number of writes issued; saturates at all-ones.

## Operation

- FSM states and transitions:
  - IDLE → READ on i_valid && o_ready. Captures i_state and i_q, and drives o_addr_r = i_state.
  - READ → CMP unconditionally. The table registers its data this cycle.
  - CMP → WRITE unconditionally. Compares i_qmax against the captured candidate and registers the results:
    - gt = cand > i_qmax;
    - o_write_en = gt;
    - o_addr_w = captured state;
    - o_data = candidate;
    - o_qmax = gt ? cand : i_qmax;
    - o_updated = gt;
    - o_done = 1.
  - WRITE → IDLE. o_write_en, o_done and o_updated clear on exit. If gt was 1, o_wr_cnt increments.
- Comparison is strict: equal values do not write.
- o_ready = 1 only in IDLE. i_valid outside IDLE is ignored, and the requester must hold its request until o_ready is 1.
- o_addr_r, o_addr_w, o_data and o_qmax hold their last values between transactions.
- No read-after-write hazard exists: the table commits the write at the end of WRITE, and the next read cannot be issued before IDLE.
- Arithmetic: compare only, no truncation. Unsigned by default; see Configuration.

## Timing

- Latency: accept edge at cycle 0. o_done, o_write_en and o_qmax are high or valid during cycle 3. The table contents are updated after the cycle 3 edge.
- Throughput: one transaction per 4 cycles. o_ready is high again in cycle 4.
- Reset (i_rst_n = 0 at an edge) forces the following values; the reset has priority over everything:
  - FSM to IDLE;
  - o_ready = 0;
  - o_write_en, o_done, o_updated = 0;
  - o_addr_r, o_addr_w, o_data, o_qmax = 0;
  - o_wr_cnt = 0.
- o_ready goes to 1 at the first edge with i_rst_n = 1.
- Reset mid-transaction aborts the transaction. No write is issued and no o_done pulse occurs.
- A reset during WRITE clears o_write_en at that edge. The table's write at the same edge still happens, because the table has no reset.
- o_wr_cnt saturates at the all-ones value and does not wrap.

## Configuration

- QMAX_SIGNED_EN defined: i_q and i_qmax are compared as two's-complement signed values. Example: 8'hFF (−1) < 8'h01.
- QMAX_SIGNED_EN undefined (default): comparison is unsigned. Example: 8'hFF > 8'h01.
- No other behaviour changes between the two settings.

## Test plan

The bench table model has mem[i] = i at start.

- Reset, then state=5, q=9 → in cycle 3: o_write_en=1, o_addr_w=5, o_data=9, o_qmax=9, o_updated=1; o_wr_cnt=1; afterwards mem[5]=9.
- state=20, q=20 (equal) → o_done=1, o_write_en=0, o_updated=0, o_qmax=20; mem[20] unchanged.
- Back-to-back: state=3, q=10, then state=3, q=7 → first request writes 10; second reads 10 and produces no write, o_qmax=10; o_ready low for cycles 1–3 of each transaction.
- i_rst_n pulsed low during CMP of state=8, q=50 → no o_write_en and no o_done; mem[8]=8; all outputs zero; o_ready=1 one edge after release.
- Signedness, state=1, q=8'hFF: undefined macro → write, o_qmax=8'hFF; with QMAX_SIGNED_EN → no write, o_qmax=8'h01.
- CNT_WIDTH=2, five successful writes → o_wr_cnt reads 1, 2, 3, 3, 3.
